onehot_addr_guard: RTL and testbench
====================================

Name: onehot_addr_guard

Overview:
- Hardened one-hot address path for register-file read and write select logic.
- Encodes a binary address into a one-hot vector and passes it through an optimisation-resistant buffer stage.
- Independently checks a one-hot vector against the original address and enable.
- Reports a combinational error and a sticky registered error for the core's alert logic.

Parameters:
- AddrWidth, 5, width of the binary address input.
- OneHotWidth, 2**AddrWidth, number of one-hot lines; must satisfy OneHotWidth <= 2**AddrWidth.
- AddrCheck, 1, when 1 the set one-hot bit must match addr_i.
- EnableCheck, 1, when 1 the presence or absence of a set bit must match en_i.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  asynchronous active-high reset.
- addr_i  input  AddrWidth  binary address to encode and check against.
- en_i  input  1  encode enable / expected-valid flag.
- oh_o  output  OneHotWidth  encoder output, combinational.
- oh_buf_o  output  OneHotWidth  buffered copy of oh_o.
- oh_i  input  OneHotWidth  vector under check; normally tied to oh_buf_o, exposed for fault injection.
- err_o  output  1  combinational check error for the current cycle.
- err_sticky_o  output  1  registered, sticky OR of err_o.

Behaviour:
- Encoder (combinational):
  - oh_o[k] = en_i && (addr_i == k), for k in 0..OneHotWidth-1.
  - en_i=0 gives all zeros.
  - addr_i >= OneHotWidth gives all zeros, with no other effect.
- Buffer:
  - oh_buf_o = oh_o bit-for-bit, zero latency.
  - Implemented as a separate buffer instance carrying keep/dont-touch attributes so synthesis cannot merge the encoder with the checker.
- Checker (combinational, inputs oh_i, addr_i, en_i). Three error terms:
  - onehot_err = more than one bit of oh_i set. Always active.
  - enable_err (EnableCheck=1 only) = (en_i && oh_i == 0) || (!en_i && oh_i != 0).
  - addr_err (AddrCheck=1 only) = en_i && (addr_i >= OneHotWidth || oh_i[addr_i] == 0).
  - addr_err is suppressed when en_i=0.
  - Any disabled term is forced to 0.
- err_o = onehot_err | enable_err | addr_err, combinational from inputs, same cycle.
- Sticky register:
  - err_q <= err_q | err_o on each rising clk_i.
  - err_sticky_o = err_q, so it asserts one cycle after err_o is first seen high.
  - Cleared only by reset.
- Reset:
  - rst_i=1 asynchronously clears err_q to 0 (err_sticky_o=0 immediately).
  - Reset mid-operation clears a latched error; err_o stays purely combinational and is unaffected by reset.
- No other state; oh_o, oh_buf_o and err_o have no reset value and depend only on the current inputs.
- With oh_i tied to oh_buf_o and addr_i < OneHotWidth, err_o is 0 for every addr_i/en_i combination (fault-free invariant).
- With oh_i tied to oh_buf_o and en_i=1, an out-of-range addr_i asserts err_o via addr_err/enable_err.
- Reads of register index 0 by the surrounding register file are outside this block's scope.

Test Plan:
- Loopback sweep: oh_i=oh_buf_o, en_i=1, addr_i=0..31 -> oh_o=1<<addr_i, err_o=0 throughout; en_i=0 -> oh_o=0, err_o=0.
- Multi-hot injection: en_i=1, addr_i=3, oh_i=0x0000_0018 -> err_o=1 in the same cycle; err_sticky_o=1 after the next edge and held after oh_i is restored.
- Address mismatch: en_i=1, addr_i=5, oh_i=0x0000_0040 -> err_o=1. With AddrCheck=0 -> err_o=0.
- Enable mismatch: en_i=0, oh_i=0x0000_0001 -> err_o=1. en_i=1, oh_i=0 -> err_o=1. With EnableCheck=0, both cases give err_o=0 when addr_err is also 0 (use AddrCheck=0 for the en_i=1 case).
- Out-of-range: AddrWidth=5, OneHotWidth=16, en_i=1, addr_i=20, oh_i=oh_buf_o -> oh_o=0, err_o=1.
- Reset: latch the sticky error, then assert rst_i asynchronously between edges -> err_sticky_o=0 immediately and stays 0 after release while err_o=0.

Source files
------------

// File: rtl/onehot_addr_guard.sv
// Hardened one-hot address path: binary-to-one-hot encoder, a protected buffer stage,
// and an independent checker that flags multi-hot, enable and address inconsistencies.

module onehot_addr_guard_buf #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] in_i,
    output logic [Width-1:0] out_o
);

    // Kept as a distinct net so the encoder and checker cones cannot be merged
    (* keep = "true", dont_touch = "true" *) logic [Width-1:0] buf_net;

    assign buf_net = in_i;
    assign out_o   = buf_net;

endmodule

module onehot_addr_guard #(
    parameter int AddrWidth   = 5,
    parameter int OneHotWidth = 2 ** AddrWidth,
    parameter bit AddrCheck   = 1'b1,
    parameter bit EnableCheck = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   en_i,
    output logic [OneHotWidth-1:0] oh_o,
    output logic [OneHotWidth-1:0] oh_buf_o,
    input  logic [OneHotWidth-1:0] oh_i,
    output logic                   err_o,
    output logic                   err_sticky_o
);

    localparam logic [AddrWidth:0] NumLines = (AddrWidth + 1)'(OneHotWidth);

    logic [OneHotWidth-1:0] oh_enc;
    logic                   addr_in_range;
    logic                   onehot_err;
    logic                   enable_err;
    logic                   addr_err;
    logic                   addr_hit;
    logic                   seen_set;
    logic                   err_sticky_d;
    logic                   err_sticky_q;

    assign addr_in_range = ({1'b0, addr_i} < NumLines);

    always_comb begin
        oh_enc = '0;
        for (int k = 0; k < OneHotWidth; k++) begin
            if (en_i && (addr_i == AddrWidth'(k))) begin
                oh_enc[k] = 1'b1;
            end
        end
    end

    assign oh_o = oh_enc;

    (* keep_hierarchy = "yes", dont_touch = "true" *)
    onehot_addr_guard_buf #(
        .Width (OneHotWidth)
    ) u_buf (
        .in_i  (oh_enc),
        .out_o (oh_buf_o)
    );

    // The checker only looks at oh_i, never at the encoder, so it stays independent
    always_comb begin
        onehot_err = 1'b0;
        seen_set   = 1'b0;
        addr_hit   = 1'b0;
        for (int k = 0; k < OneHotWidth; k++) begin
            if (oh_i[k] && seen_set) begin
                onehot_err = 1'b1;
            end
            if (oh_i[k]) begin
                seen_set = 1'b1;
            end
            if (oh_i[k] && (addr_i == AddrWidth'(k))) begin
                addr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        enable_err = 1'b0;
        addr_err   = 1'b0;
        if (EnableCheck) begin
            enable_err = (en_i && !(|oh_i)) || (!en_i && (|oh_i));
        end
        if (AddrCheck) begin
            addr_err = en_i && (!addr_in_range || !addr_hit);
        end
    end

    assign err_o        = onehot_err | enable_err | addr_err;
    assign err_sticky_d = err_sticky_q | err_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_onehot_addr_guard.sv
// Scoreboard bench for onehot_addr_guard: three instances (full checks, checks disabled,
// narrowed one-hot range) share address/enable stimulus and are compared against a reference model.

module tb_onehot_addr_guard;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic        en;
    logic        inject;
    logic [31:0] oh_inj;

    logic [31:0] oh_m, buf_m, ohi_m;
    logic        err_m, st_m;
    logic [31:0] oh_n, buf_n, ohi_n;
    logic        err_n, st_n;
    logic [15:0] oh_w, buf_w, ohi_w;
    logic        err_w, st_w;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] oh;
        logic [15:0] oh_w;
        logic        err_m;
        logic        err_n;
        logic        err_w;
        logic        st_m;
        logic        st_n;
        logic        st_w;
    } exp_t;

    exp_t sb[$];

    logic sticky_m = 1'b0, sticky_n = 1'b0, sticky_w = 1'b0;
    logic prev_m = 1'b0, prev_n = 1'b0, prev_w = 1'b0;

    assign ohi_m = inject ? oh_inj : buf_m;
    assign ohi_n = inject ? oh_inj : buf_n;
    assign ohi_w = inject ? oh_inj[15:0] : buf_w;

    onehot_addr_guard dut_main (
        .clk_i (clk), .rst_i (rst), .addr_i (addr), .en_i (en),
        .oh_o (oh_m), .oh_buf_o (buf_m), .oh_i (ohi_m),
        .err_o (err_m), .err_sticky_o (st_m)
    );

    onehot_addr_guard #(.AddrCheck(1'b0), .EnableCheck(1'b0)) dut_nochk (
        .clk_i (clk), .rst_i (rst), .addr_i (addr), .en_i (en),
        .oh_o (oh_n), .oh_buf_o (buf_n), .oh_i (ohi_n),
        .err_o (err_n), .err_sticky_o (st_n)
    );

    onehot_addr_guard #(.AddrWidth(5), .OneHotWidth(16)) dut_narrow (
        .clk_i (clk), .rst_i (rst), .addr_i (addr), .en_i (en),
        .oh_o (oh_w), .oh_buf_o (buf_w), .oh_i (ohi_w),
        .err_o (err_w), .err_sticky_o (st_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_oh(input int a, input logic e, input int w);
        if (e && a < w) return 32'd1 << a;
        return 32'd0;
    endfunction

    function automatic logic model_err(input logic [31:0] v, input int a, input logic e,
                                       input int w, input bit ac, input bit ec);
        logic multi, en_e, ad_e;
        multi = ($countones(v) > 1);
        en_e  = ec && ((e && v == 32'd0) || (!e && v != 32'd0));
        ad_e  = ac && e && ((a >= w) || (v[a] == 1'b0));
        return multi | en_e | ad_e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one transaction just after a rising edge and queues what the DUTs should show
    task automatic applyStimulus(input logic [4:0] a, input logic e, input logic inj,
                                 input logic [31:0] pat);
        exp_t        x;
        logic [31:0] ohw_full;
        logic [31:0] chk_m;
        logic [31:0] chk_w;
        @(posedge clk);
        #1;
        sticky_m = sticky_m | prev_m;
        sticky_n = sticky_n | prev_n;
        sticky_w = sticky_w | prev_w;
        addr   = a;
        en     = e;
        inject = inj;
        oh_inj = pat;
        x.oh     = model_oh(int'(a), e, 32);
        ohw_full = model_oh(int'(a), e, 16);
        x.oh_w   = ohw_full[15:0];
        chk_m    = inj ? pat : x.oh;
        chk_w    = inj ? (pat & 32'h0000_ffff) : ohw_full;
        x.err_m  = model_err(chk_m, int'(a), e, 32, 1'b1, 1'b1);
        x.err_n  = model_err(chk_m, int'(a), e, 32, 1'b0, 1'b0);
        x.err_w  = model_err(chk_w, int'(a), e, 16, 1'b1, 1'b1);
        x.st_m   = sticky_m;
        x.st_n   = sticky_n;
        x.st_w   = sticky_w;
        prev_m   = x.err_m;
        prev_n   = x.err_n;
        prev_w   = x.err_w;
        sb.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checkOutput("oh_main",     oh_m,  x.oh);
                checkOutput("ohbuf_main",  buf_m, x.oh);
                checkOutput("err_main",    {31'd0, err_m}, {31'd0, x.err_m});
                checkOutput("sticky_main", {31'd0, st_m},  {31'd0, x.st_m});
                checkOutput("oh_nochk",    oh_n,  x.oh);
                checkOutput("err_nochk",   {31'd0, err_n}, {31'd0, x.err_n});
                checkOutput("sticky_nochk",{31'd0, st_n},  {31'd0, x.st_n});
                checkOutput("oh_narrow",   {16'd0, oh_w},  {16'd0, x.oh_w});
                checkOutput("ohbuf_narrow",{16'd0, buf_w}, {16'd0, x.oh_w});
                checkOutput("err_narrow",  {31'd0, err_w}, {31'd0, x.err_w});
                checkOutput("sticky_narrow",{31'd0, st_w}, {31'd0, x.st_w});
            end
        end
    end

    initial begin
        logic [31:0] pat;
        rst    = 1'b1;
        addr   = 5'd0;
        en     = 1'b0;
        inject = 1'b0;
        oh_inj = 32'd0;
        #3;
        checkOutput("reset_sticky_main",   {31'd0, st_m}, 32'd0);
        checkOutput("reset_sticky_narrow", {31'd0, st_w}, 32'd0);
        checkOutput("reset_err_main",      {31'd0, err_m}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 32; i++) applyStimulus(5'(i), 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++)  applyStimulus(5'($urandom_range(0, 31)), 1'b0, 1'b0, 32'd0);

        applyStimulus(5'd3, 1'b1, 1'b1, 32'h0000_0018);
        applyStimulus(5'd3, 1'b1, 1'b0, 32'd0);
        applyStimulus(5'd3, 1'b1, 1'b0, 32'd0);
        applyStimulus(5'd5, 1'b1, 1'b1, 32'h0000_0040);
        applyStimulus(5'd0, 1'b0, 1'b1, 32'h0000_0001);
        applyStimulus(5'd0, 1'b1, 1'b1, 32'h0000_0000);
        applyStimulus(5'd20, 1'b1, 1'b0, 32'd0);
        applyStimulus(5'd2, 1'b1, 1'b0, 32'd0);

        // Asynchronous reset between edges while a latched error is held
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_clear_main",   {31'd0, st_m}, 32'd0);
        checkOutput("async_clear_nochk",  {31'd0, st_n}, 32'd0);
        checkOutput("async_clear_narrow", {31'd0, st_w}, 32'd0);
        checkOutput("reset_keeps_err",    {31'd0, err_m}, 32'd0);
        sticky_m = 1'b0;
        sticky_n = 1'b0;
        sticky_w = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("release_sticky_main", {31'd0, st_m}, 32'd0);
        applyStimulus(5'd2, 1'b1, 1'b0, 32'd0);
        applyStimulus(5'd2, 1'b1, 1'b0, 32'd0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       pat = $urandom;
                1:       pat = 32'd1 << $urandom_range(0, 31);
                2:       pat = 32'd0;
                default: pat = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
            endcase
            applyStimulus(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) == 0), pat);
        end

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
